// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM bank-port definitions: port widths, read-slot FSM state
// encodings and a small helper that picks one 16-bit word out of the
// 32-bit word pair returned by the bank mux.
package jtframe_sdram_pkg;

    // Bank mux port geometry
    localparam int BANK_AW   = 22;
    localparam int BANK_DW   = 32;
    localparam int BANK_HALF = 16;

    // Read-slot FSM state encodings
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_ACK = ST_WAIT_ACK,
        WAIT_RDY = ST_WAIT_RDY
    } rdslot_state_t;

    // The bank returns the even word in the low half and the odd word in the
    // high half, so address bit 0 selects between them.
    function automatic logic [BANK_HALF-1:0] pick_half(
        input logic [BANK_DW-1:0] pair,
        input logic               odd
    );
        return odd ? pair[BANK_DW-1:BANK_HALF] : pair[BANK_HALF-1:0];
    endfunction

endpackage

// File: rtl/jtframe_bank_rdslot.sv
// Single-entry read cache between a game read port and one SDRAM bank of the
// bank mux. Each SDRAM access fetches an aligned 32-bit word pair; reads of
// either word of the cached pair are served without touching the SDRAM.
//
// Build option JTFRAME_BANKSLOT_CACHE_EN: when defined, the cached pair stays
// valid while slot_cs is low, so re-reading it later needs no SDRAM access.
// When undefined, the cached pair is dropped whenever slot_cs is low in IDLE,
// so every new request goes to the SDRAM.
module jtframe_bank_rdslot
    import jtframe_sdram_pkg::*;
#(
    parameter int AW = BANK_AW,
    parameter int DW = 16
)(
    input  logic               rst,
    input  logic               clk,
    input  logic               slot_cs,
    input  logic [AW-1:0]      slot_addr,
    input  logic               slot_clr,
    output logic               slot_ok,
    output logic [DW-1:0]      slot_dout,
    output logic [AW-1:0]      sdram_addr,
    output logic               sdram_rd,
    input  logic               sdram_ack,
    input  logic               sdram_rdy,
    input  logic [BANK_DW-1:0] sdram_din
);

    rdslot_state_t      state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-2:0]      tag_q, tag_d;
    logic [BANK_DW-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               clr_pend_q, clr_pend_d;
    logic               ok_q, ok_d;
    logic [DW-1:0]      dout_q, dout_d;

    logic               hit;
    logic               fill;
    logic               fill_keep;
    logic               fill_hit;

    // Hit/fill qualification. A fill counts as a hit for the requester in the
    // very cycle the data arrives, which gives one cycle of miss latency after
    // sdram_rdy. A clear seen at any point during the fetch spoils the fill.
    always_comb begin
        hit       = valid_q && (tag_q == slot_addr[AW-1:1]);
        fill      = ((state_q == WAIT_ACK) && sdram_ack && sdram_rdy) ||
                    ((state_q == WAIT_RDY) && sdram_rdy);
        fill_keep = fill && !slot_clr && !clr_pend_q;
        fill_hit  = fill_keep && slot_cs && (addr_q[AW-1:1] == slot_addr[AW-1:1]);
    end

    // Next-state logic for the fetch FSM and the cache entry
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        data_d     = data_q;
        valid_d    = valid_q;
        clr_pend_d = clr_pend_q;

        case (state_q)
            IDLE: begin
                clr_pend_d = 1'b0;
                if (slot_cs && !hit) begin
                    state_d = WAIT_ACK;
                    addr_d  = {slot_addr[AW-1:1], 1'b0};
                end
            end
            WAIT_ACK: begin
                if (slot_clr) clr_pend_d = 1'b1;
                if (sdram_ack) state_d = sdram_rdy ? IDLE : WAIT_RDY;
            end
            WAIT_RDY: begin
                if (slot_clr) clr_pend_d = 1'b1;
                if (sdram_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fill) begin
            data_d = sdram_din;
            tag_d  = addr_q[AW-1:1];
            if (fill_keep) valid_d = 1'b1;
        end

`ifdef JTFRAME_BANKSLOT_CACHE_EN
`else
        if ((state_q == IDLE) && !slot_cs) valid_d = 1'b0;
`endif

        if (slot_clr) valid_d = 1'b0;
    end

    // Registered read response: data comes straight from the bus on a fill,
    // otherwise from the cached pair; dout holds its value between responses.
    always_comb begin
        ok_d   = slot_cs && (hit || fill_hit);
        dout_d = dout_q;
        if (ok_d) begin
            dout_d = DW'(pick_half(fill_hit ? sdram_din : data_q, slot_addr[0]));
        end
    end

    // State and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            clr_pend_q <= 1'b0;
            ok_q       <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            clr_pend_q <= clr_pend_d;
            ok_q       <= ok_d;
            dout_q     <= dout_d;
        end
    end

    assign sdram_rd   = (state_q == WAIT_ACK);
    assign sdram_addr = addr_q;
    assign slot_ok    = ok_q;
    assign slot_dout  = dout_q;

endmodule

// File: tb/tb_jtframe_bank_rdslot.sv
// Self-checking bench for jtframe_bank_rdslot. A 16-bit and an 8-bit instance
// share one stimulus stream; expected read data is queued when a request is
// issued and compared when slot_ok shows up.
module tb_jtframe_bank_rdslot;

    logic        clock = 1'b0;
    logic        reset;
    logic        slotCs;
    logic [21:0] slotAddr;
    logic        slotClr;
    logic        sdramAck;
    logic        sdramRdy;
    logic [31:0] sdramDin;

    logic        slotOk, slotOk8;
    logic [15:0] slotDout;
    logic [7:0]  slotDout8;
    logic [21:0] sdramAddr, sdramAddr8;
    logic        sdramRd, sdramRd8;

    typedef struct packed {
        logic [15:0] d16;
        logic [7:0]  d8;
    } expect_t;

    expect_t expQ[$];
    int      assertCount = 0;
    int      failCount   = 0;

`ifdef JTFRAME_BANKSLOT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    jtframe_bank_rdslot #(.AW(22), .DW(16)) dut (
        .rst        (reset),
        .clk        (clock),
        .slot_cs    (slotCs),
        .slot_addr  (slotAddr),
        .slot_clr   (slotClr),
        .slot_ok    (slotOk),
        .slot_dout  (slotDout),
        .sdram_addr (sdramAddr),
        .sdram_rd   (sdramRd),
        .sdram_ack  (sdramAck),
        .sdram_rdy  (sdramRdy),
        .sdram_din  (sdramDin)
    );

    jtframe_bank_rdslot #(.AW(22), .DW(8)) dut8 (
        .rst        (reset),
        .clk        (clock),
        .slot_cs    (slotCs),
        .slot_addr  (slotAddr),
        .slot_clr   (slotClr),
        .slot_ok    (slotOk8),
        .slot_dout  (slotDout8),
        .sdram_addr (sdramAddr8),
        .sdram_rd   (sdramRd8),
        .sdram_ack  (sdramAck),
        .sdram_rdy  (sdramRdy),
        .sdram_din  (sdramDin)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic cs, input logic [21:0] addr,
                                 input logic clr, input logic ack,
                                 input logic rdy, input logic [31:0] din);
        slotCs   = cs;
        slotAddr = addr;
        slotClr  = clr;
        sdramAck = ack;
        sdramRdy = rdy;
        sdramDin = din;
    endtask

    task automatic pushExpect(input logic [15:0] d16, input logic [7:0] d8);
        expect_t e;
        e.d16 = d16;
        e.d8  = d8;
        expQ.push_back(e);
    endtask

    // Waits up to budget cycles for slot_ok, then pops and compares.
    // Returns one cycle after the response was seen.
    task automatic expectOk(input string tag, input int budget);
        expect_t e;
        bit      seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (slotOk) begin
                seen = 1'b1;
                if (expQ.size() == 0) begin
                    checkOutput({tag, "_queue"}, 32'd0, 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({tag, "_dout"},  {16'd0, slotDout},  {16'd0, e.d16});
                    checkOutput({tag, "_dout8"}, {24'd0, slotDout8}, {24'd0, e.d8});
                    checkOutput({tag, "_ok8"},   {31'd0, slotOk8},   32'd1);
                end
            end
            nextCycle();
        end
        if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 22'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("rst_ok",    {31'd0, slotOk},   32'd0);
        checkOutput("rst_dout",  {16'd0, slotDout}, 32'd0);
        checkOutput("rst_dout8", {24'd0, slotDout8}, 32'd0);
        checkOutput("rst_rd",    {31'd0, sdramRd},  32'd0);
        checkOutput("rst_addr",  {10'd0, sdramAddr}, 32'd0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        // Plain miss with split ack/rdy; address change mid-fetch is ignored
        applyStimulus(1'b1, 22'h101, 1'b0, 1'b0, 1'b0, 32'h0);
        pushExpect(16'hBEEF, 8'hEF);
        checkOutput("miss_rd_t0", {31'd0, sdramRd}, 32'd0);
        nextCycle();
        checkOutput("miss_rd_t1",   {31'd0, sdramRd},    32'd1);
        checkOutput("miss_addr_t1", {10'd0, sdramAddr},  32'h100);
        checkOutput("miss_rd8_t1",  {31'd0, sdramRd8},   32'd1);
        checkOutput("miss_addr8",   {10'd0, sdramAddr8}, 32'h100);
        nextCycle();
        applyStimulus(1'b1, 22'h777, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("miss_rd_t2", {31'd0, sdramRd}, 32'd1);
        nextCycle();
        applyStimulus(1'b1, 22'h777, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("miss_rd_t3",   {31'd0, sdramRd},   32'd1);
        checkOutput("miss_addr_t3", {10'd0, sdramAddr}, 32'h100);
        nextCycle();
        applyStimulus(1'b1, 22'h101, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("miss_rd_t4", {31'd0, sdramRd}, 32'd0);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 22'h101, 1'b0, 1'b0, 1'b1, 32'hBEEF1234);
        checkOutput("miss_ok_t7", {31'd0, slotOk}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 22'h101, 1'b0, 1'b0, 1'b0, 32'h0);
        expectOk("miss", 1);

        // Re-read of the other word after cs low for two cycles
        applyStimulus(1'b0, 22'h101, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 22'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        pushExpect(16'h1234, 8'h34);
        nextCycle();
        if (CACHE_EN) begin
            checkOutput("hit_rd", {31'd0, sdramRd}, 32'd0);
            expectOk("hit", 1);
        end else begin
            checkOutput("refetch_rd", {31'd0, sdramRd}, 32'd1);
            applyStimulus(1'b1, 22'h100, 1'b0, 1'b1, 1'b1, 32'hBEEF1234);
            nextCycle();
            applyStimulus(1'b1, 22'h100, 1'b0, 1'b0, 1'b0, 32'h0);
            expectOk("refetch", 1);
        end
        applyStimulus(1'b0, 22'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();

        // cs dropped mid-fetch: fetch completes, no response, pair is filled
        applyStimulus(1'b1, 22'h400, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("drop_rd", {31'd0, sdramRd}, 32'd1);
        applyStimulus(1'b0, 22'h400, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 22'h400, 1'b0, 1'b0, 1'b1, 32'h55556666);
        nextCycle();
        applyStimulus(1'b0, 22'h400, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("drop_ok", {31'd0, slotOk}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 22'h401, 1'b0, 1'b0, 1'b0, 32'h0);
        pushExpect(16'h5555, 8'h55);
        nextCycle();
        if (CACHE_EN) begin
            checkOutput("drop_hit_rd", {31'd0, sdramRd}, 32'd0);
            expectOk("drop_hit", 1);
        end else begin
            checkOutput("drop_refetch_rd", {31'd0, sdramRd}, 32'd1);
            applyStimulus(1'b1, 22'h401, 1'b0, 1'b1, 1'b1, 32'h55556666);
            nextCycle();
            applyStimulus(1'b1, 22'h401, 1'b0, 1'b0, 1'b0, 32'h0);
            expectOk("drop_refetch", 1);
        end
        applyStimulus(1'b0, 22'h401, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();

        // Clear coincident with rdy: fill discarded, refetch right away
        applyStimulus(1'b1, 22'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("clr_rd", {31'd0, sdramRd}, 32'd1);
        applyStimulus(1'b1, 22'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 22'h200, 1'b1, 1'b0, 1'b1, 32'h11112222);
        nextCycle();
        applyStimulus(1'b1, 22'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("clr_ok",   {31'd0, slotOk},  32'd0);
        checkOutput("clr_rd_0", {31'd0, sdramRd}, 32'd0);
        nextCycle();
        checkOutput("clr_refetch_rd",   {31'd0, sdramRd},   32'd1);
        checkOutput("clr_refetch_addr", {10'd0, sdramAddr}, 32'h200);
        pushExpect(16'h4444, 8'h44);
        applyStimulus(1'b1, 22'h200, 1'b0, 1'b1, 1'b1, 32'h33334444);
        nextCycle();
        applyStimulus(1'b1, 22'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        expectOk("clr_refetch", 1);
        applyStimulus(1'b0, 22'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();

        // Combined ack+rdy on an odd address, byte lane on the 8-bit instance
        applyStimulus(1'b1, 22'h003, 1'b0, 1'b0, 1'b0, 32'h0);
        pushExpect(16'hA1B2, 8'hB2);
        nextCycle();
        checkOutput("comb_rd",   {31'd0, sdramRd},   32'd1);
        checkOutput("comb_addr", {10'd0, sdramAddr}, 32'h002);
        applyStimulus(1'b1, 22'h003, 1'b0, 1'b1, 1'b1, 32'hA1B2C3D4);
        nextCycle();
        applyStimulus(1'b1, 22'h003, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("comb_rd_after", {31'd0, sdramRd}, 32'd0);
        expectOk("comb", 1);
        applyStimulus(1'b0, 22'h003, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();

        // Reset in WAIT_RDY, late rdy after release must be ignored
        applyStimulus(1'b1, 22'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 22'h500, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 22'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 22'h500, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b0, 22'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rstmid_ok",   {31'd0, slotOk},    32'd0);
        checkOutput("rstmid_rd",   {31'd0, sdramRd},   32'd0);
        checkOutput("rstmid_addr", {10'd0, sdramAddr}, 32'd0);
        nextCycle();
        checkOutput("rstmid_ok_1", {31'd0, slotOk}, 32'd0);
        applyStimulus(1'b1, 22'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("rstmid_refetch_rd",   {31'd0, sdramRd},   32'd1);
        checkOutput("rstmid_refetch_addr", {10'd0, sdramAddr}, 32'h500);
        pushExpect(16'h8888, 8'h88);
        applyStimulus(1'b1, 22'h500, 1'b0, 1'b1, 1'b1, 32'h77778888);
        nextCycle();
        applyStimulus(1'b1, 22'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        expectOk("rstmid_refetch", 1);
        applyStimulus(1'b0, 22'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();

        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
